// File: rtl/rvc_asap_5pl_fpga_in_cond.sv
// Input conditioning for the CR memory: 2-flop synchronizer plus per-channel
// debounce for the board buttons and switches, with press / change pulses.
module rvc_asap_5pl_fpga_in_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned SW_W            = 10
) (
    input  logic            Clock,
    input  logic            Rst,
    input  logic            Button_0_raw,
    input  logic            Button_1_raw,
    input  logic [SW_W-1:0] Switch_raw,
    output logic            Button_0,
    output logic            Button_1,
    output logic [SW_W-1:0] Switch,
    output logic            Button_0_press,
    output logic            Button_1_press,
    output logic            Switch_chg
);

    localparam int unsigned    NCH     = SW_W + 2;
    localparam int unsigned    CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel map: bit 0 = button 0, bit 1 = button 1, bits NCH-1:2 = switches.
    logic [NCH-1:0]   ch_in;
    logic [NCH-1:0]   s1_q, s2_q;
    logic [NCH-1:0]   st_q, st_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic             b0_press_q, b0_press_d;
    logic             b1_press_q, b1_press_d;
    logic             sw_chg_q, sw_chg_d;

    always_comb begin
        ch_in = {Switch_raw,
                 Button_1_raw ^ BTN_ACTIVE_LOW,
                 Button_0_raw ^ BTN_ACTIVE_LOW};
    end

    always_comb begin
        st_d = st_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    st_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // Pulses are registered alongside st so they align with the new level.
        b0_press_d = st_d[0] & ~st_q[0];
        b1_press_d = st_d[1] & ~st_q[1];
        sw_chg_d   = |(st_d[NCH-1:2] ^ st_q[NCH-1:2]);
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            st_q       <= '0;
            b0_press_q <= 1'b0;
            b1_press_q <= 1'b0;
            sw_chg_q   <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= ch_in;
            s2_q       <= s1_q;
            st_q       <= st_d;
            b0_press_q <= b0_press_d;
            b1_press_q <= b1_press_d;
            sw_chg_q   <= sw_chg_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign Button_0       = st_q[0];
    assign Button_1       = st_q[1];
    assign Switch         = st_q[NCH-1:2];
    assign Button_0_press = b0_press_q;
    assign Button_1_press = b1_press_q;
    assign Switch_chg     = sw_chg_q;

endmodule

// File: tb/tb_rvc_asap_5pl_fpga_in_cond.sv
// Bench for rvc_asap_5pl_fpga_in_cond: directed vector table, async-reset
// sequences and random stimulus against a sliding-window debounce model.
module tb_rvc_asap_5pl_fpga_in_cond;

    localparam int unsigned D = 4;

    logic       Clock = 1'b0;
    logic       Rst = 1'b0;
    logic       b0r, b1r;
    logic [9:0] swr;
    logic       Button_0, Button_1, Button_0_press, Button_1_press, Switch_chg;
    logic [9:0] Switch;

    int unsigned total = 0;
    int unsigned bad   = 0;

    rvc_asap_5pl_fpga_in_cond #(
        .DEBOUNCE_CYCLES(D),
        .BTN_ACTIVE_LOW (1'b1),
        .SW_W           (10)
    ) dut (
        .Clock         (Clock),
        .Rst           (Rst),
        .Button_0_raw  (b0r),
        .Button_1_raw  (b1r),
        .Switch_raw    (swr),
        .Button_0      (Button_0),
        .Button_1      (Button_1),
        .Switch        (Switch),
        .Button_0_press(Button_0_press),
        .Button_1_press(Button_1_press),
        .Switch_chg    (Switch_chg)
    );

    always #5 Clock = ~Clock;

    // Reference: a level is accepted once the last D synchronized samples all
    // disagree with the current stable level.
    logic [11:0] m_s1, m_s2, m_st;
    logic [11:0] m_win[$];
    logic        m_p0, m_p1, m_chg;

    typedef struct {
        logic        b0r;
        logic        b1r;
        logic [9:0]  sw;
        logic [14:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [14:0] dut_out();
        return {Button_0, Button_1, Switch, Button_0_press, Button_1_press, Switch_chg};
    endfunction

    function automatic logic [14:0] model_out();
        return {m_st[0], m_st[1], m_st[11:2], m_p0, m_p1, m_chg};
    endfunction

    function automatic logic [11:0] chan();
        return {swr, ~b1r, ~b0r};
    endfunction

    function automatic void add(input int unsigned n, input logic ib0, input logic ib1,
                                input logic [9:0] isw, input logic eb0, input logic eb1,
                                input logic [9:0] esw, input logic ep0, input logic ep1,
                                input logic echg);
        vec_t v;
        v.b0r = ib0;
        v.b1r = ib1;
        v.sw  = isw;
        v.exp = {eb0, eb1, esw, ep0, ep1, echg};
        for (int unsigned k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_st = '0;
        m_p0 = 1'b0; m_p1 = 1'b0; m_chg = 1'b0;
        m_win.delete();
    endtask

    task automatic model_edge(input logic [11:0] ch);
        logic [11:0] old;
        logic [11:0] flip;
        old = m_st;
        m_win.push_back(m_s2);
        if (m_win.size() > D) void'(m_win.pop_front());
        flip = '0;
        if (m_win.size() == D) begin
            flip = '1;
            foreach (m_win[j]) flip &= (m_win[j] ^ m_st);
        end
        m_st  = m_st ^ flip;
        m_p0  = m_st[0] & ~old[0];
        m_p1  = m_st[1] & ~old[1];
        m_chg = |(m_st[11:2] ^ old[11:2]);
        m_s2  = m_s1;
        m_s1  = ch;
    endtask

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge(chan());
        #1;
    endtask

    // Called 1 time unit after an edge: pulls Rst low between edges.
    task automatic async_rst(input string name);
        #3 Rst = 1'b0;
        #1 chk(name, dut_out(), '0);
        model_reset();
        #2 Rst = 1'b1;
    endtask

    initial begin
        // Vector table (D = 4): inputs for the edge, outputs expected after it.
        add(5, 0, 1, 10'h000, 0, 0, 10'h000, 0, 0, 0);
        add(1, 0, 1, 10'h000, 1, 0, 10'h000, 1, 0, 0);
        add(1, 0, 1, 10'h000, 1, 0, 10'h000, 0, 0, 0);
        add(5, 1, 1, 10'h000, 1, 0, 10'h000, 0, 0, 0);
        add(2, 1, 1, 10'h000, 0, 0, 10'h000, 0, 0, 0);
        add(5, 1, 1, 10'h201, 0, 0, 10'h000, 0, 0, 0);
        add(1, 1, 1, 10'h201, 0, 0, 10'h201, 0, 0, 1);
        add(1, 1, 1, 10'h201, 0, 0, 10'h201, 0, 0, 0);
        add(3, 1, 0, 10'h201, 0, 0, 10'h201, 0, 0, 0);
        add(5, 1, 1, 10'h201, 0, 0, 10'h201, 0, 0, 0);
        add(4, 1, 0, 10'h201, 0, 0, 10'h201, 0, 0, 0);
        add(1, 1, 1, 10'h201, 0, 0, 10'h201, 0, 0, 0);
        add(1, 1, 1, 10'h201, 0, 1, 10'h201, 0, 1, 0);
        add(3, 1, 1, 10'h201, 0, 1, 10'h201, 0, 0, 0);
        add(2, 1, 1, 10'h201, 0, 0, 10'h201, 0, 0, 0);
        add(1, 1, 1, 10'h209, 0, 0, 10'h201, 0, 0, 0);
        add(1, 1, 1, 10'h201, 0, 0, 10'h201, 0, 0, 0);
        add(1, 1, 1, 10'h209, 0, 0, 10'h201, 0, 0, 0);
        add(1, 1, 1, 10'h201, 0, 0, 10'h201, 0, 0, 0);
        add(5, 1, 1, 10'h209, 0, 0, 10'h201, 0, 0, 0);
        add(1, 1, 1, 10'h209, 0, 0, 10'h209, 0, 0, 1);
        add(1, 1, 1, 10'h209, 0, 0, 10'h209, 0, 0, 0);

        // Reset held with button 0 pressed: nothing may come out.
        b0r = 1'b0; b1r = 1'b1; swr = '0;
        model_reset();
        repeat (3) @(posedge Clock);
        #1 chk("reset_state", dut_out(), '0);
        #3 Rst = 1'b1;

        foreach (tbl[i]) begin
            b0r = tbl[i].b0r;
            b1r = tbl[i].b1r;
            swr = tbl[i].sw;
            tick();
            chk($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // Reset while a switch change is two counts into debounce.
        swr = 10'h20B;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("midcnt_e%0d", k), dut_out(), {2'b00, 10'h209, 3'b000});
        end
        async_rst("midcnt_async");
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("redeb_e%0d", k), dut_out(), '0);
        end
        tick();
        chk("redeb_e6", dut_out(), {2'b00, 10'h20B, 3'b001});
        tick();
        chk("redeb_e7", dut_out(), {2'b00, 10'h20B, 3'b000});

        // Random stimulus: each raw bit flips with probability 1/5 per cycle.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(4) == 0) b0r = ~b0r;
            if ($urandom_range(4) == 0) b1r = ~b1r;
            for (int b = 0; b < 10; b++) begin
                if ($urandom_range(4) == 0) swr[b] = ~swr[b];
            end
            tick();
            chk($sformatf("rand%0d", n), dut_out(), model_out());
            if ($urandom_range(149) == 0) async_rst($sformatf("rand_rst%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvc_asap_5pl_fpga_in_cond.md
Name: rvc_asap_5pl_fpga_in_cond

Overview:
- Input-conditioning stage directly upstream of the CR memory.
- Takes raw, asynchronous FPGA board inputs (2 push-buttons, 10 slide switches) and synchronizes each to Clock.
- Debounces each input and delivers clean levels that drive the CR memory's Button_0, Button_1 and Switch inputs.
- Also produces single-cycle press pulses and a switch-change pulse for future interrupt/event use.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized cycles required before a level change is accepted (1 ms at 50 MHz); legal range >= 1.
- BTN_ACTIVE_LOW, 1: 1 = raw buttons read 0 when pressed (board KEYs); inverted at input so outputs are 1 = pressed.
- SW_W, 10: number of switch inputs.

Ports:
- Clock  in  1  core clock, all state on rising edge.
- Rst  in  1  asynchronous, active-low reset (0 = reset asserted, takes effect immediately, independent of Clock).
- Button_0_raw  in  1  raw board button 0, asynchronous.
- Button_1_raw  in  1  raw board button 1, asynchronous.
- Switch_raw  in  SW_W  raw board switches, asynchronous, 1 = up.
- Button_0  out  1  debounced button 0, 1 = pressed; feeds CR memory.
- Button_1  out  1  debounced button 1, 1 = pressed; feeds CR memory.
- Switch  out  SW_W  debounced switches; feeds CR memory.
- Button_0_press  out  1  one-cycle pulse on debounced 0->1 of Button_0.
- Button_1_press  out  1  one-cycle pulse on debounced 0->1 of Button_1.
- Switch_chg  out  1  one-cycle pulse when any debounced Switch bit changes.

Behaviour:
- Channels: 2 + SW_W independent, identical channels. Channel i input = raw bit, inverted for buttons when BTN_ACTIVE_LOW = 1.
- Synchronizer: 2-flop chain per channel (s1 <= in, s2 <= s1). Both flops reset to 0, i.e. the unpressed / switch-down level after inversion.
- Per-channel state: stable level st (drives the output) and counter cnt, width max(1, $clog2(DEBOUNCE_CYCLES)).
- Each rising edge:
  - s2 == st: cnt <= 0.
  - s2 != st and cnt == DEBOUNCE_CYCLES-1: st <= s2, cnt <= 0.
  - s2 != st otherwise: cnt <= cnt + 1.
- Counter range: cnt never exceeds DEBOUNCE_CYCLES-1; no wrap is possible.
- Latency: a raw level first sampled on edge 1 and held stable appears on the output after edge 2+DEBOUNCE_CYCLES. Example: DEBOUNCE_CYCLES = 4 gives edge 6.
- Glitch rejection:
  - Any excursion of s2 shorter than DEBOUNCE_CYCLES cycles leaves st unchanged.
  - cnt restarts from 0 on every return to st.
  - Bounce therefore only extends latency; it never produces an extra output toggle.
- Pulses:
  - Button_x_press is 1 in exactly the cycle in which Button_x first reads 1, i.e. registered together with the st update. It is 0 on release.
  - Switch_chg is 1 for one cycle when any Switch bit's st updates, either direction. If several bits update on the same edge, a single one-cycle pulse is issued.
- Reset values: all outputs 0; all st, cnt and sync flops 0.
- Reset mid-debounce:
  - Asserting Rst immediately clears every st, cnt and pulse.
  - No pulse is generated on reset assertion or release.
  - After release, an input already at its active level requires the full 2+DEBOUNCE_CYCLES latency and then yields a press pulse.
- Timing: all outputs are direct flop outputs, with no combinational path from any raw input.
- Simultaneous events: channels are fully independent; there is no arbitration.

Test Plan:
- Reset: Rst = 0 with Button_0_raw = 0 (pressed) → all outputs 0 during reset. Release with input held → Button_0 = 1 and Button_0_press = 1 for one cycle, 6 edges after release (DEBOUNCE_CYCLES = 4, default BTN_ACTIVE_LOW).
- Latency: DEBOUNCE_CYCLES = 4, drive Switch_raw = 10'h201 from 10'h000 → Switch = 10'h201 exactly on edge 6, Switch_chg = 1 on that edge only.
- Glitch: Button_1_raw low for 3 cycles, then high → Button_1 stays 0, no press pulse. Low for 4 cycles → Button_1 = 1 with press pulse.
- Bounce: toggle Switch_raw[3] 1,0,1,0 on 4 consecutive cycles, then hold 1 → Switch[3] rises exactly 6 edges after the final transition, single Switch_chg pulse.
- Release: hold Button_0 pressed until debounced, then release → Button_0 falls after 6 edges, Button_0_press stays 0.
- Async reset mid-count: assert Rst at cnt = 2 for a pending switch → outputs and counters cleared within the same cycle without a clock. After release, the change is re-debounced from zero.
